// File: rtl/game_pkg.sv
// Game-wide state encodings shared by the game FSM, the collision detector and the ball engine.
// Also holds the ball engine's own FSM state type.
package game_pkg;

    localparam logic [2:0] ST_MAIN_MENU  = 3'd0;
    localparam logic [2:0] ST_LEVEL1     = 3'd1;
    localparam logic [2:0] ST_END_SCREEN = 3'd2;

    typedef enum logic [1:0] {
        BALL_IDLE  = 2'd0,
        BALL_SERVE = 2'd1,
        BALL_MOVE  = 2'd2,
        BALL_LOST  = 2'd3
    } ball_state_e;

endpackage

// File: rtl/motion_tick_gen.sv
// Motion tick divider: counts clock cycles while enabled and pulses tick on the
// last cycle of each TICK_DIV-cycle window. The count is held at zero when disabled.
module motion_tick_gen #(
    parameter int TICK_DIV = 833333
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);
    localparam int               CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign tick = enable && (count_q == CNT_LAST);

    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (!enable || tick) count_d = '0;
    end

    always_ff @(posedge clock) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end

endmodule

// File: rtl/ball_motion_engine.sv
// Ball kinematics for the brick-breaker: tracks the paddle while serving, moves on motion ticks,
// bounces off walls, applies collision flags, ramps speed and reports a lost ball.
module ball_motion_engine
    import game_pkg::*;
#(
    parameter int COORD_W   = 8,
    parameter int X_MAX     = 159,
    parameter int Y_MAX     = 119,
    parameter int MAX_SPEED = 3,
    parameter int SPD_W     = 2,
    parameter int PADDLE_Y  = 112,
    parameter int PADDLE_W  = 16,
    parameter int TICK_DIV  = 833333
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [2:0]         state,
    input  logic               launch,
    input  logic [COORD_W-1:0] paddle_x,
    input  logic               hit_paddle,
    input  logic               hit_brick_x,
    input  logic               hit_brick_y,
    input  logic               speed_up,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic               dir_x,
    output logic               dir_y,
    output logic [SPD_W-1:0]   speed,
    output logic               moving,
    output logic               ball_lost
);
    // One spare bit so x+speed / y+speed comparisons cannot wrap.
    localparam int                 AW        = COORD_W + 1;
    localparam logic [AW-1:0]      X_LIM     = AW'(X_MAX);
    localparam logic [AW-1:0]      Y_LIM     = AW'(Y_MAX);
    localparam logic [AW-1:0]      SERVE_OFS = AW'(PADDLE_W / 2);
    localparam logic [COORD_W-1:0] X_EDGE    = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] SERVE_Y   = COORD_W'(PADDLE_Y - 1);
    localparam logic [SPD_W-1:0]   SPD_MAX   = SPD_W'(MAX_SPEED);
    localparam logic [SPD_W-1:0]   SPD_INIT  = SPD_W'(1);

    ball_state_e        fsm_q, fsm_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               dx_q, dx_d, dy_q, dy_d;
    logic [SPD_W-1:0]   spd_q, spd_d;
    logic               pad_q, pad_d, bx_q, bx_d, by_q, by_d;
    logic               moving_q, lost_q;

    logic               tick, in_level, tick_en;
    logic [AW-1:0]      x_w, y_w, spd_w, serve_x_w;
    logic [COORD_W-1:0] serve_x;
    logic               pad_eff, bx_eff, by_eff, dx_new, dy_new;

    assign tick_en = (fsm_q == BALL_MOVE);

    motion_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .enable(tick_en),
        .tick  (tick)
    );

    assign in_level  = (state == ST_LEVEL1);
    assign x_w       = AW'(x_q);
    assign y_w       = AW'(y_q);
    assign spd_w     = AW'(spd_q);
    assign serve_x_w = AW'(paddle_x) + SERVE_OFS;
    assign serve_x   = (serve_x_w > X_LIM) ? X_EDGE : COORD_W'(serve_x_w);

    // Flags raised on the tick cycle itself count toward that tick.
    assign pad_eff = pad_q | hit_paddle;
    assign bx_eff  = bx_q  | hit_brick_x;
    assign by_eff  = by_q  | hit_brick_y;
    assign dy_new  = pad_eff ? 1'b1 : (dy_q ^ by_eff);
    assign dx_new  = dx_q ^ bx_eff;

    always_comb begin
        fsm_d = fsm_q;
        x_d   = x_q;
        y_d   = y_q;
        dx_d  = dx_q;
        dy_d  = dy_q;
        spd_d = spd_q;
        pad_d = 1'b0;
        bx_d  = 1'b0;
        by_d  = 1'b0;

        if (!in_level) begin
            fsm_d = BALL_IDLE;
        end else begin
            case (fsm_q)
                BALL_IDLE:  fsm_d = BALL_SERVE;
                BALL_SERVE: if (launch) fsm_d = BALL_MOVE;
                BALL_LOST:  fsm_d = BALL_SERVE;
                BALL_MOVE: begin
                    if (tick) begin
                        dx_d = dx_new;
                        dy_d = dy_new;
                        if (!dx_new) begin
                            if (x_w + spd_w >= X_LIM) begin
                                x_d  = X_EDGE;
                                dx_d = 1'b1;
                            end else begin
                                x_d = COORD_W'(x_w + spd_w);
                            end
                        end else if (x_w <= spd_w) begin
                            x_d  = '0;
                            dx_d = 1'b0;
                        end else begin
                            x_d = COORD_W'(x_w - spd_w);
                        end
                        if (dy_new) begin
                            if (y_w <= spd_w) begin
                                y_d  = '0;
                                dy_d = 1'b0;
                            end else begin
                                y_d = COORD_W'(y_w - spd_w);
                            end
                        end else if (y_w + spd_w > Y_LIM) begin
                            fsm_d = BALL_LOST;
                        end else begin
                            y_d = COORD_W'(y_w + spd_w);
                        end
                    end else begin
                        pad_d = pad_eff;
                        bx_d  = bx_eff;
                        by_d  = by_eff;
                    end
                    if (speed_up && (spd_q < SPD_MAX)) spd_d = spd_q + SPD_W'(1);
                end
                default: fsm_d = BALL_IDLE;
            endcase
        end

        // Serve position is loaded on entry so it is visible the cycle SERVE starts.
        if (in_level && ((fsm_q == BALL_SERVE) || (fsm_d == BALL_SERVE))) begin
            x_d   = serve_x;
            y_d   = SERVE_Y;
            dx_d  = 1'b0;
            dy_d  = 1'b1;
            spd_d = SPD_INIT;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            fsm_q    <= BALL_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            dx_q     <= 1'b0;
            dy_q     <= 1'b1;
            spd_q    <= SPD_INIT;
            pad_q    <= 1'b0;
            bx_q     <= 1'b0;
            by_q     <= 1'b0;
            moving_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            spd_q    <= spd_d;
            pad_q    <= pad_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            moving_q <= (fsm_d == BALL_MOVE);
            lost_q   <= (fsm_d == BALL_LOST);
        end
    end

    assign ball_x    = x_q;
    assign ball_y    = y_q;
    assign dir_x     = dx_q;
    assign dir_y     = dy_q;
    assign speed     = spd_q;
    assign moving    = moving_q;
    assign ball_lost = lost_q;

endmodule

// File: tb/tb_ball_motion_engine.sv
// Bench for ball_motion_engine: directed table, hand-written corner sequences and random
// stimulus, all checked against a behavioural model of the ball rules.
module tb_ball_motion_engine;
    import game_pkg::*;

    localparam int TD = 4;
    localparam int MD_IDLE = 0, MD_SERVE = 1, MD_MOVE = 2, MD_LOST = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] state;
    logic       launch;
    logic [7:0] paddle_x;
    logic       hit_paddle, hit_brick_x, hit_brick_y, speed_up;
    logic [7:0] ball_x, ball_y;
    logic       dir_x, dir_y;
    logic [1:0] speed;
    logic       moving, ball_lost;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: velocity signs, integer position, tick phase.
    int m_mode, m_x, m_y, m_vx, m_vy, m_spd, m_ph, m_ticks;
    bit m_fp, m_fbx, m_fby;

    typedef struct {
        logic       rst;
        logic [2:0] st;
        logic       lau;
        logic [7:0] px;
        int         ex, ey, espd;
        logic       emov, elost;
    } vec_t;
    vec_t tbl[12];

    ball_motion_engine #(.TICK_DIV(TD)) dut (
        .clock(clock), .reset(reset), .state(state), .launch(launch), .paddle_x(paddle_x),
        .hit_paddle(hit_paddle), .hit_brick_x(hit_brick_x), .hit_brick_y(hit_brick_y),
        .speed_up(speed_up), .ball_x(ball_x), .ball_y(ball_y), .dir_x(dir_x), .dir_y(dir_y),
        .speed(speed), .moving(moving), .ball_lost(ball_lost)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got running, want finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit was_serve, fp, fbx, fby;
        if (!reset) begin
            m_mode = MD_IDLE; m_x = 0; m_y = 0; m_vx = 1; m_vy = -1; m_spd = 1;
            m_fp = 0; m_fbx = 0; m_fby = 0;
            return;
        end
        was_serve = (m_mode == MD_SERVE);
        if (state != ST_LEVEL1) begin
            m_mode = MD_IDLE; m_fp = 0; m_fbx = 0; m_fby = 0;
            return;
        end
        case (m_mode)
            MD_IDLE:  m_mode = MD_SERVE;
            MD_LOST:  m_mode = MD_SERVE;
            MD_SERVE: if (launch) begin m_mode = MD_MOVE; m_ph = 0; end
            default: begin
                fp  = m_fp  | hit_paddle;
                fbx = m_fbx | hit_brick_x;
                fby = m_fby | hit_brick_y;
                m_ph++;
                if (m_ph == TD) begin
                    m_ph = 0;
                    m_ticks++;
                    if (fp) m_vy = -1;
                    else if (fby) m_vy = -m_vy;
                    if (fbx) m_vx = -m_vx;
                    if (m_vx > 0) begin
                        if (m_x + m_spd >= 159) begin m_x = 159; m_vx = -1; end
                        else m_x = m_x + m_spd;
                    end else begin
                        if (m_x <= m_spd) begin m_x = 0; m_vx = 1; end
                        else m_x = m_x - m_spd;
                    end
                    if (m_vy < 0) begin
                        if (m_y <= m_spd) begin m_y = 0; m_vy = 1; end
                        else m_y = m_y - m_spd;
                    end else if (m_y + m_spd > 119) begin
                        m_mode = MD_LOST;
                    end else begin
                        m_y = m_y + m_spd;
                    end
                    m_fp = 0; m_fbx = 0; m_fby = 0;
                end else begin
                    m_fp = fp; m_fbx = fbx; m_fby = fby;
                end
                if (speed_up) m_spd = (m_spd >= 3) ? 3 : m_spd + 1;
            end
        endcase
        if (was_serve || m_mode == MD_SERVE) begin
            m_x = (int'(paddle_x) + 8 > 159) ? 159 : int'(paddle_x) + 8;
            m_y = 111; m_vx = 1; m_vy = -1; m_spd = 1;
        end
    endtask

    task automatic cmp_model();
        chk("model_x",      int'(ball_x),    m_x);
        chk("model_y",      int'(ball_y),    m_y);
        chk("model_dir_x",  int'(dir_x),     (m_vx < 0) ? 1 : 0);
        chk("model_dir_y",  int'(dir_y),     (m_vy < 0) ? 1 : 0);
        chk("model_speed",  int'(speed),     m_spd);
        chk("model_moving", int'(moving),    (m_mode == MD_MOVE) ? 1 : 0);
        chk("model_lost",   int'(ball_lost), (m_mode == MD_LOST) ? 1 : 0);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        cmp_model();
    endtask

    task automatic wait_ticks(input int n);
        int target;
        int budget;
        target = m_ticks + n;
        budget = n * TD + 8;
        while (m_ticks < target && budget > 0) begin
            step();
            budget--;
        end
        if (m_ticks < target) begin
            n_tests++;
            n_fail++;
            $display("FAIL tick_wait: got %0d ticks, want %0d", m_ticks, target);
        end
    endtask

    task automatic go_idle();
        state = ST_MAIN_MENU; launch = 0; speed_up = 0;
        hit_paddle = 0; hit_brick_x = 0; hit_brick_y = 0;
        step();
        step();
    endtask

    task automatic serve_launch(input logic [7:0] px);
        state = ST_LEVEL1; paddle_x = px;
        step();
        step();
        launch = 1;
        step();
        launch = 0;
    endtask

    initial begin
        reset = 0; state = ST_MAIN_MENU; launch = 0; paddle_x = 0;
        hit_paddle = 0; hit_brick_x = 0; hit_brick_y = 0; speed_up = 0;
        m_ticks = 0; m_ph = 0; m_mode = MD_IDLE;

        // reset, idle hold, serve tracking, launch and first tick
        tbl[0]  = '{1'b0, ST_MAIN_MENU, 1'b0, 8'd0,  0,   0,   1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, ST_MAIN_MENU, 1'b0, 8'd0,  0,   0,   1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, ST_MAIN_MENU, 1'b0, 8'd0,  0,   0,   1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, ST_MAIN_MENU, 1'b0, 8'd0,  0,   0,   1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, ST_MAIN_MENU, 1'b0, 8'd0,  0,   0,   1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, ST_LEVEL1,    1'b0, 8'd40, 48,  111, 1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, ST_LEVEL1,    1'b0, 8'd50, 58,  111, 1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, ST_LEVEL1,    1'b1, 8'd50, 58,  111, 1, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, ST_LEVEL1,    1'b0, 8'd50, 58,  111, 1, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, ST_LEVEL1,    1'b0, 8'd50, 58,  111, 1, 1'b1, 1'b0};
        tbl[10] = '{1'b1, ST_LEVEL1,    1'b0, 8'd50, 58,  111, 1, 1'b1, 1'b0};
        tbl[11] = '{1'b1, ST_LEVEL1,    1'b0, 8'd50, 59,  110, 1, 1'b1, 1'b0};

        for (int i = 0; i < 12; i++) begin
            reset = tbl[i].rst; state = tbl[i].st; launch = tbl[i].lau; paddle_x = tbl[i].px;
            step();
            chk($sformatf("vec%0d_x", i),     int'(ball_x),    tbl[i].ex);
            chk($sformatf("vec%0d_y", i),     int'(ball_y),    tbl[i].ey);
            chk($sformatf("vec%0d_spd", i),   int'(speed),     tbl[i].espd);
            chk($sformatf("vec%0d_mov", i),   int'(moving),    int'(tbl[i].emov));
            chk($sformatf("vec%0d_lost", i),  int'(ball_lost), int'(tbl[i].elost));
        end
        launch = 0;

        // Speed 2: climb to the top wall, bounce, fall out of the bottom.
        go_idle();
        serve_launch(8'd40);
        speed_up = 1;
        step();
        speed_up = 0;
        wait_ticks(55);
        chk("A_y_at_1", int'(ball_y), 1);
        chk("A_up_at_1", int'(dir_y), 1);
        wait_ticks(1);
        chk("A_top_y", int'(ball_y), 0);
        chk("A_top_dir", int'(dir_y), 0);
        wait_ticks(59);
        chk("A_y_118", int'(ball_y), 118);
        chk("A_speed2", int'(speed), 2);
        wait_ticks(1);
        chk("A_lost_pulse", int'(ball_lost), 1);
        chk("A_lost_y_held", int'(ball_y), 118);
        chk("A_lost_not_moving", int'(moving), 0);
        step();
        chk("A_lost_one_cycle", int'(ball_lost), 0);
        chk("A_reserve_x", int'(ball_x), 48);
        chk("A_reserve_y", int'(ball_y), 111);

        // Speed 3: right wall at x=158.
        go_idle();
        serve_launch(8'd60);
        speed_up = 1;
        step();
        step();
        speed_up = 0;
        wait_ticks(30);
        chk("B_x_158", int'(ball_x), 158);
        chk("B_y_21", int'(ball_y), 21);
        chk("B_speed3", int'(speed), 3);
        wait_ticks(1);
        chk("B_wall_x", int'(ball_x), 159);
        chk("B_wall_dir", int'(dir_x), 1);
        wait_ticks(1);
        chk("B_back_x", int'(ball_x), 156);

        // Collision precedence, single toggle, saturation, abort to IDLE.
        go_idle();
        serve_launch(8'd20);
        step();
        hit_paddle = 1; hit_brick_y = 1; hit_brick_x = 1;
        step();
        hit_paddle = 0; hit_brick_y = 0; hit_brick_x = 0;
        wait_ticks(1);
        chk("C_paddle_wins", int'(dir_y), 1);
        chk("C_y_110", int'(ball_y), 110);
        chk("C_bx_toggle", int'(dir_x), 1);
        chk("C_x_27", int'(ball_x), 27);
        step();
        hit_brick_y = 1;
        step();
        hit_brick_y = 0;
        wait_ticks(1);
        chk("C_by_toggle", int'(dir_y), 0);
        chk("C_y_111", int'(ball_y), 111);
        wait_ticks(1);
        chk("C_by_once", int'(dir_y), 0);
        chk("C_y_112", int'(ball_y), 112);
        speed_up = 1;
        for (int i = 0; i < 4; i++) step();
        speed_up = 0;
        chk("C_speed_sat", int'(speed), 3);
        hit_brick_x = 1;
        step();
        hit_brick_x = 0;
        state = ST_END_SCREEN;
        step();
        chk("C_abort_moving", int'(moving), 0);
        serve_launch(8'd20);
        wait_ticks(1);
        chk("C_sticky_cleared_dir", int'(dir_x), 0);
        chk("C_sticky_cleared_x", int'(ball_x), 29);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(399) != 0);
            state       = ($urandom_range(59) == 0) ? 3'($urandom_range(2)) : ST_LEVEL1;
            launch      = ($urandom_range(5) == 0);
            paddle_x    = 8'($urandom_range(255));
            hit_paddle  = ($urandom_range(11) == 0);
            hit_brick_x = ($urandom_range(11) == 0);
            hit_brick_y = ($urandom_range(11) == 0);
            speed_up    = ($urandom_range(19) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
